// File: rtl/fc_frame_sequencer.sv
// fc_frame_sequencer: gathers a frame of activations from a valid/ready stream
// into a parallel vector for a combinational neuron, waits for the neuron path
// to settle, then returns the neuron result on a valid/ready output stream.
module fc_frame_sequencer #(
  parameter int WIDTH   = 8,
  parameter int IN      = 128,
  parameter int Z_WIDTH = 23,
  parameter int SETTLE  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  input  logic                  s_last,
  output logic [IN*WIDTH-1:0]   x_vec,
  input  logic [Z_WIDTH-1:0]    z_in,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [Z_WIDTH-1:0]    m_data,
  output logic                  frame_err
);

  localparam int IDX_W = (IN > 1) ? $clog2(IN) : 1;
  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_WAIT,
    ST_OUT
  } state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 m_valid_reg, m_valid_next;
  logic [Z_WIDTH-1:0]   m_data_reg, m_data_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 wr_en;
  logic                 fill_ready;
  logic [WIDTH-1:0]     x_reg [IN];

  // Control registers: state, element index, settle counter, result and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_FILL;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      m_valid_reg   <= 1'b0;
      m_data_reg    <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      cnt_reg       <= cnt_next;
      m_valid_reg   <= m_valid_next;
      m_data_reg    <= m_data_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Next-state logic: fill the vector, wait for the neuron to settle, hold the result
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    cnt_next       = cnt_reg;
    m_valid_next   = m_valid_reg;
    m_data_next    = m_data_reg;
    frame_err_next = 1'b0;
    wr_en          = 1'b0;
    fill_ready     = 1'b0;
    case (state_reg)
      ST_FILL: begin
        fill_ready = 1'b1;
        if (s_valid) begin
          wr_en = 1'b1;
          if (idx_reg == IDX_LAST) begin
            // Full frame: a missing s_last is flagged but the frame still runs
            state_next     = ST_WAIT;
            cnt_next       = '0;
            idx_next       = '0;
            frame_err_next = !s_last;
          end else if (s_last) begin
            // Early end: drop the partial frame and start over
            idx_next       = '0;
            frame_err_next = 1'b1;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_LAST) begin
          m_data_next  = z_in;
          m_valid_next = 1'b1;
          state_next   = ST_OUT;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          m_valid_next = 1'b0;
          idx_next     = '0;
          state_next   = ST_FILL;
        end
      end
      default: begin
        state_next = ST_FILL;
      end
    endcase
  end

  // One register per vector element, written only when its index is addressed
  generate
    for (genvar gi = 0; gi < IN; gi++) begin : g_elem
      always_ff @(posedge clk) begin
        if (rst) begin
          x_reg[gi] <= '0;
        end else if (wr_en && (idx_reg == IDX_W'(gi))) begin
          x_reg[gi] <= s_data;
        end
      end
      assign x_vec[gi*WIDTH +: WIDTH] = x_reg[gi];
    end
  endgenerate

  assign s_ready   = fill_ready && !rst;
  assign m_valid   = m_valid_reg;
  assign m_data    = m_data_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_fc_frame_sequencer.sv
// Scoreboard bench for fc_frame_sequencer: stimulus pushes expected results,
// a monitor pops and compares them when the DUT presents a result.
module tb_fc_frame_sequencer;

  localparam int WIDTH   = 8;
  localparam int IN      = 128;
  localparam int Z_WIDTH = 23;
  localparam int SETTLE  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [WIDTH-1:0]    s_data = '0;
  logic                s_last = 1'b0;
  logic [IN*WIDTH-1:0] x_vec;
  logic [Z_WIDTH-1:0]  z_in;
  logic                m_valid;
  logic                m_ready = 1'b0;
  logic [Z_WIDTH-1:0]  m_data;
  logic                frame_err;

  fc_frame_sequencer #(
    .WIDTH(WIDTH), .IN(IN), .Z_WIDTH(Z_WIDTH), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .x_vec(x_vec), .z_in(z_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int n_hs  = 0;
  int bp_mode = 0;            // 0: always ready, 1: hold off 10 cycles, 2: random
  logic [Z_WIDTH-1:0] last_hs = '0;

  // Reference model state
  logic [7:0]          cur_q[$];
  logic [IN*WIDTH-1:0] exp_x_q[$];
  logic [Z_WIDTH-1:0]  exp_z_q[$];
  int                  lat_q[$];
  bit                  err_at[int];

  // Neuron stand-in: weight 1 on taps 0..73, weight 2 on tap 47, then ReLU
  function automatic int weight(input int i);
    return ((i <= 73) ? 1 : 0) + ((i == 47) ? 1 : 0);
  endfunction

  function automatic logic [Z_WIDTH-1:0] neuron(input logic [IN*WIDTH-1:0] xv);
    int acc = 0;
    for (int i = 0; i < IN; i++) acc += int'($signed(xv[i*WIDTH +: WIDTH])) * weight(i);
    if (acc < 0) acc = 0;
    return Z_WIDTH'(acc);
  endfunction

  assign z_in = neuron(x_vec);

  function automatic int xdiff(input logic [IN*WIDTH-1:0] a, input logic [IN*WIDTH-1:0] b);
    int d = 0;
    for (int i = 0; i < IN; i++) if (a[i*WIDTH +: WIDTH] !== b[i*WIDTH +: WIDTH]) d++;
    return d;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model of one accepted beat, called at the negedge before the accepting edge
  task automatic on_beat(input logic [7:0] d, input logic last);
    logic [IN*WIDTH-1:0] v;
    cur_q.push_back(d);
    if (cur_q.size() == IN) begin
      for (int i = 0; i < IN; i++) v[i*WIDTH +: WIDTH] = cur_q[i];
      exp_x_q.push_back(v);
      exp_z_q.push_back(neuron(v));
      lat_q.push_back(cyc + 1);
      if (!last) err_at[cyc + 1] = 1'b1;
      cur_q.delete();
    end else if (last) begin
      err_at[cyc + 1] = 1'b1;
      cur_q.delete();
    end
  endtask

  // Send n beats; s_last on beat last_at (-1 for none); stall_pct% idle cycles
  task automatic send_frame(input int n, input int last_at, input int stall_pct, input bit rnd);
    logic [7:0] vals [IN];
    int sent = 0;
    int guard = 0;
    for (int i = 0; i < IN; i++) vals[i] = rnd ? 8'($urandom_range(255)) : 8'(i);
    while (sent < n) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout: got %0d beats, expected %0d", sent, n);
        break;
      end
      if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = vals[sent];
        s_last  = (sent == last_at);
      end
      if (s_valid && s_ready) begin
        on_beat(s_data, s_last);
        sent++;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    #1;
    chk("s_ready_in_rst", s_ready, 0);
    cur_q.delete(); exp_x_q.delete(); exp_z_q.delete(); lat_q.delete(); err_at.delete();
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_x_vec_nonzero_elems", xdiff(x_vec, '0), 0);
    rst = 1'b0;
    #1;
    chk("s_ready_after_rst", s_ready, 1);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_z_q.size() != 0 || m_valid) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        n_cmp++; n_err++;
        $display("FAIL drain_timeout: got %0d results pending, expected 0", exp_z_q.size());
        break;
      end
    end
    @(negedge clk);
  endtask

  // Monitor: frame_err every cycle, result compare/latency/hold, m_ready policy
  initial begin : monitor
    bit prev_v = 1'b0;
    bit hs_pend = 1'b0;
    int vcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0; hs_pend = 1'b0; vcnt = 0;
        continue;
      end
      chk("frame_err", frame_err, err_at.exists(cyc) ? 1 : 0);
      if (hs_pend) begin
        chk("reentry_s_ready", s_ready, 1);
        chk("m_valid_after_hs", m_valid, 0);
        hs_pend = 1'b0;
      end
      if (m_valid) begin
        if (exp_z_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_m_valid: got m_data 0x%0h, expected no result", m_data);
          m_ready = 1'b1;
          prev_v = 1'b0;
        end else begin
          if (!prev_v) begin
            chk("latency", cyc - lat_q.pop_front(), SETTLE);
            vcnt = 0;
          end
          chk("m_data", m_data, exp_z_q[0]);
          chk("s_ready_while_out", s_ready, 0);
          chk("x_vec_diff_elems", xdiff(x_vec, exp_x_q[0]), 0);
          case (bp_mode)
            0: m_ready = 1'b1;
            1: m_ready = (vcnt >= 10);
            default: m_ready = ($urandom_range(2) == 0);
          endcase
          if (m_ready) begin
            last_hs = m_data;
            void'(exp_z_q.pop_front());
            void'(exp_x_q.pop_front());
            hs_pend = 1'b1;
            n_hs++;
          end
          vcnt++;
          prev_v = !m_ready;
        end
      end else begin
        prev_v = 1'b0;
        m_ready = (bp_mode == 0);
      end
    end
  end

  initial begin : main
    int hs0;
    int guard;
    do_reset();

    // Basic frame, m_ready held high through WAIT
    bp_mode = 0;
    send_frame(IN, IN - 1, 0, 1'b0);
    wait_drain();
    chk("basic_z", last_hs, 'hABC);
    chk("x_elem5", x_vec[5*WIDTH +: WIDTH], 5);

    // Backpressure
    bp_mode = 1;
    send_frame(IN, IN - 1, 0, 1'b1);
    wait_drain();

    // Early last on beat 50, then a full frame yields exactly one result
    bp_mode = 0;
    hs0 = n_hs;
    send_frame(51, 50, 0, 1'b1);
    send_frame(IN, IN - 1, 0, 1'b1);
    wait_drain();
    chk("early_last_results", n_hs - hs0, 1);

    // Missing last
    send_frame(IN, -1, 0, 1'b1);
    wait_drain();

    // Input stalls on the basic frame
    send_frame(IN, IN - 1, 30, 1'b0);
    wait_drain();
    chk("stall_z", last_hs, 'hABC);

    // Reset after beat 60, then a full frame
    send_frame(61, -1, 0, 1'b1);
    do_reset();
    send_frame(IN, IN - 1, 0, 1'b1);
    wait_drain();

    // Reset while a result is pending
    bp_mode = 1;
    send_frame(IN, IN - 1, 0, 1'b1);
    guard = 0;
    while (!m_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("pending_before_rst", m_valid, 1);
    do_reset();

    // Random frames with random stalls and random backpressure
    bp_mode = 2;
    for (int f = 0; f < 4; f++) begin
      send_frame(IN, IN - 1, int'($urandom_range(40)), 1'b1);
    end
    wait_drain();

    chk("results_left", exp_z_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fc_frame_sequencer.md
# fc_frame_sequencer

Streaming front end for a fully-connected neuron block. It collects a frame of `IN` signed `WIDTH`-bit activations from a valid/ready byte stream into a parallel vector register and drives that register onto the neuron's `x` inputs. It waits a fixed settle time for the combinational multiply/adder-tree/ReLU path, then captures the neuron's `z` output and returns it on a valid/ready result stream. It is the writer side of the neuron's parallel input interface and the reader side of its output.

## Interface

Parameters:
- `WIDTH`, default 8: activation width in bits.
- `IN`, default 128: elements per frame.
- `Z_WIDTH`, default 23: neuron output width (`WIDTH*2 + clog2(active taps)`).
- `SETTLE`, default 2: cycles allowed for the combinational neuron path to settle; legal range is 1 or more.

Ports:
- `clk`, input, 1: the single clock; all logic is rising-edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `s_valid`, input, 1: input beat valid.
- `s_ready`, output, 1: block accepts an input beat.
- `s_data`, input, `WIDTH`: activation value.
- `s_last`, input, 1: marks the final beat of a frame.
- `x_vec`, output, `IN*WIDTH`: registered vector; element i is at `[i*WIDTH +: WIDTH]`.
- `z_in`, input, `Z_WIDTH`: neuron result, combinational from `x_vec`.
- `m_valid`, output, 1: result valid.
- `m_ready`, input, 1: downstream accepts the result.
- `m_data`, output, `Z_WIDTH`: captured result.
- `frame_err`, output, 1: one-cycle pulse on a framing error.

## Operation

- The state machine has three states: FILL, WAIT, OUT. Reset enters FILL with `idx`=0.
- **FILL**
  - `s_ready`=1.
  - On a beat (`s_valid && s_ready`), `s_data` is written to element `idx`, then `idx` increments.
  - `s_last` on a beat with `idx` < `IN-1` is an early end. The block pulses `frame_err`, sets `idx` to 0, stays in FILL and discards the partial frame. Elements already written stay in `x_vec` until overwritten.
  - The beat with `idx`=`IN-1` goes to WAIT with `cnt`=0. If `s_last`=0 on that beat, `frame_err` pulses but the frame is still processed.
- **WAIT**
  - `s_ready`=0 and `x_vec` is frozen.
  - `cnt` increments every cycle.
  - In the cycle with `cnt`=`SETTLE-1`, `z_in` is registered into `m_data`, `m_valid` is set, and the state moves to OUT.
- **OUT**
  - `s_ready`=0.
  - `m_valid` and `m_data` are held stable until `m_ready`.
  - On handshake, `m_valid` clears, `idx` goes to 0 and the state returns to FILL.
- Input and output frames never overlap; `x_vec` must not change while the result is pending.
- Widths: `idx` is `clog2(IN)` bits and `cnt` is `clog2(SETTLE+1)` bits. `idx` never wraps silently; it is reset explicitly at a frame boundary or error.
- `m_data` is a raw copy of `z_in`. There is no sign extension or saturation, because ReLU is already applied upstream.

## Timing

- Reset values take effect on the edge where `rst`=1, and `rst` overrides all other inputs:
  - state FILL, `idx` 0, `cnt` 0
  - `x_vec` all zeros
  - `m_valid` 0, `m_data` 0, `frame_err` 0
- `s_ready` is 0 during any cycle with `rst`=1 and is combinational from state otherwise.
- Asserting `rst` mid-frame or mid-result discards everything. `m_valid` drops without a handshake.
- Latency: last beat accepted at edge T gives `m_valid`=1 from cycle T+1+`SETTLE` (T+3 at default).
- Re-entry: a result handshake at edge U gives `s_ready`=1 in cycle U+1.
- Minimum frame period is `IN`+`SETTLE`+1 cycles.
- `frame_err` is high for exactly the one cycle after the offending beat.
- `s_valid` gaps stall FILL with no side effects.
- `m_ready` held high while in WAIT completes the handshake in the first OUT cycle.

## Test plan

- **Basic frame:**
  - Stimulus: after reset, stream 128 beats with `s_data`=i&0xFF and `s_last` on beat 127; the bench model drives `z_in` from `x_vec`, giving 0x000ABC for this frame.
  - Required: `x_vec` element 5 reads 5; `m_valid` rises 3 cycles after the last beat; `m_data`=0x000ABC; `frame_err` never pulses.
- **Backpressure:**
  - Stimulus: hold `m_ready`=0 for 10 cycles after `m_valid` rises.
  - Required: `m_valid` and `m_data` stay constant and `s_ready`=0 throughout; `s_ready`=1 the cycle after the handshake.
- **Early last:**
  - Stimulus: `s_last` on beat 50.
  - Required: one-cycle `frame_err`, no `m_valid`; the next 128 beats produce exactly one correct result.
- **Missing last:**
  - Stimulus: 128 beats with no `s_last`.
  - Required: `frame_err` pulse in the cycle after beat 127; the result is still delivered.
- **Input stalls:**
  - Stimulus: the basic frame with `s_valid` randomly deasserted about 30% of cycles.
  - Required: `m_data` identical to the basic frame.
- **Reset mid-frame:**
  - Stimulus: `rst` pulsed for 1 cycle after beat 60, then a full frame.
  - Required: reset values on the next cycle; the following frame's result is correct and no stale elements leak in.
